// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
package store_buffer_pkg;
   localparam int SB_DEPTH = 4;
   // word-index slice used for load/store matching
   localparam int WIDX_HI = 11;
   localparam int WIDX_LO = 2;
   localparam int WIDX_W  = WIDX_HI - WIDX_LO + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] pc;
   } sbEntry_t;
endpackage

// File: rtl/store_buffer_match.sv
// sb_match: per-entry word-index compare, then picks the youngest matching entry.
module sb_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = 2
) (
   input  logic [DEPTH-1:0][WIDX_W-1:0] entryIdx,
   input  logic [DEPTH-1:0]             validMask,
   input  logic [PTR_W-1:0]             head,
   input  logic [WIDX_W-1:0]            ldIdx,
   output logic [DEPTH-1:0]             youngest
);
   logic [DEPTH-1:0] match;

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : gCmp
         assign match[i] = validMask[i] && (entryIdx[i] == ldIdx);
      end
   endgenerate

   // walk entries oldest to youngest starting at head; the last hit wins
   always_comb begin
      logic [PTR_W-1:0] idx;
      youngest = '0;
      idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (match[idx]) begin
            youngest      = '0;
            youngest[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores draining to memory, with load forwarding.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [31:0] st_pc,
   output logic        st_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hit,
   output logic [31:0] ld_data,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_pc,
   input  logic        mem_ready,
   output logic        empty,
   output logic        full
);
   logic [PTR_W-1:0]               head, tail;
   logic [PTR_W:0]                 count;
   sbEntry_t [DEPTH-1:0]           entries;
   logic [DEPTH-1:0][WIDX_W-1:0]   entryIdx;
   logic [DEPTH-1:0]               validMask, youngest;
   logic                           push, pop;
   logic [31:0]                    fwdData;
   logic                           unusedLdBits;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign st_ready = !full;
   assign mem_we   = !empty;
   assign push     = st_valid && st_ready;
   assign pop      = mem_we && mem_ready;

   assign mem_addr  = entries[head].addr;
   assign mem_wdata = entries[head].data;
   assign mem_pc    = entries[head].pc;

   // only the word index takes part in matching
   assign unusedLdBits = ^{ld_addr[31:WIDX_HI+1], ld_addr[WIDX_LO-1:0]};

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : gEnt
         logic [PTR_W-1:0] age;
         assign age          = PTR_W'(i) - head;
         assign validMask[i] = ({1'b0, age} < count);
         assign entryIdx[i]  = entries[i].addr[WIDX_HI:WIDX_LO];
      end
   endgenerate

   sb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uMatch (
      .entryIdx  (entryIdx),
      .validMask (validMask),
      .head      (head),
      .ldIdx     (ld_addr[WIDX_HI:WIDX_LO]),
      .youngest  (youngest)
   );

   // one-hot select of the forwarded word
   always_comb begin
      fwdData = '0;
      for (int k = 0; k < DEPTH; k++)
         if (youngest[k]) fwdData = fwdData | entries[k].data;
   end

   assign ld_hit  = ld_valid && (|youngest);
   assign ld_data = ld_hit ? fwdData : '0;

   // pointer and occupancy update; reset wins over push/pop
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   // entry write at tail; contents need no reset
   always_ff @(posedge clk) begin
      if (push && !reset) entries[tail] <= '{addr: st_addr, data: st_data, pc: st_pc};
   end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench: queue-based reference model plus a decoupled memory-write scoreboard.
module tb_store_buffer;
   import store_buffer_pkg::*;
   localparam int D = 4;

   logic        clk = 0, reset;
   logic        st_valid, ld_valid, mem_ready;
   logic [31:0] st_addr, st_data, st_pc, ld_addr;
   logic        st_ready, ld_hit, mem_we, empty, full;
   logic [31:0] ld_data, mem_addr, mem_wdata, mem_pc;

   int vectors = 0, miscompares = 0;
   sbEntry_t model[$];   // buffer contents, oldest first
   sbEntry_t expQ[$];    // writes memory is expected to see, in order

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(D), .PTR_W(2)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
      .mem_ready(mem_ready), .empty(empty), .full(full)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every write the DUT hands to memory must be the next expected one
   initial begin
      forever begin
         @(negedge clk);
         if (mem_we && mem_ready && !reset) begin
            if (expQ.size() == 0) begin
               chk("unexpected_write", 32'd1, 32'd0);
            end else begin
               chk("mem_addr",  mem_addr,  expQ[0].addr);
               chk("mem_wdata", mem_wdata, expQ[0].data);
               chk("mem_pc",    mem_pc,    expQ[0].pc);
               void'(expQ.pop_front());
            end
         end
      end
   end

   // one cycle: drive inputs, check combinational outputs against the model, advance on the edge
   task automatic step(input logic rst, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [31:0] sp, input logic mr, input logic lv, input logic [31:0] la);
      logic        eh;
      logic [31:0] ed;
      logic        acc, popd;
      reset = rst; st_valid = sv; st_addr = sa; st_data = sd; st_pc = sp;
      mem_ready = mr; ld_valid = lv; ld_addr = la;
      #1;
      eh = 0; ed = 0;
      if (lv)
         foreach (model[k])
            if (model[k].addr[11:2] == la[11:2]) begin eh = 1; ed = model[k].data; end
      chk("st_ready", st_ready, model.size() < D);
      chk("full",     full,     model.size() == D);
      chk("empty",    empty,    model.size() == 0);
      chk("mem_we",   mem_we,   model.size() != 0);
      chk("ld_hit",   ld_hit,   eh);
      chk("ld_data",  ld_data,  ed);
      acc  = sv && (model.size() < D);
      popd = mr && (model.size() != 0);
      @(posedge clk);
      if (rst) begin
         model.delete();
         expQ.delete();
      end else begin
         if (popd) void'(model.pop_front());
         if (acc) begin
            model.push_back('{addr: sa, data: sd, pc: sp});
            expQ.push_back('{addr: sa, data: sd, pc: sp});
         end
      end
      #1;
   endtask

   task automatic idle(input logic mr);
      step(0, 0, 0, 0, 0, mr, 0, 0);
   endtask

   initial begin
      logic [31:0] ra;
      reset = 1; st_valid = 0; st_addr = 0; st_data = 0; st_pc = 0;
      mem_ready = 0; ld_valid = 0; ld_addr = 0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(0);                                   // reset state

      // 1: single store held, then drained
      step(0, 1, 32'h10, 32'hDEADBEEF, 32'h3000, 0, 0, 0);
      chk("t1_addr",  mem_addr,  32'h10);
      chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
      repeat (3) idle(0);
      idle(1);
      idle(0);

      // 2: fill, blocked 5th, then accepted after a pop
      for (int i = 0; i < 4; i++) step(0, 1, 32'h100 + 4*i, 32'hA0 + i, 32'h4000 + 4*i, 0, 0, 0);
      step(0, 1, 32'h200, 32'hB5, 32'h5000, 0, 0, 0);  // refused
      step(0, 1, 32'h200, 32'hB5, 32'h5000, 1, 0, 0);  // full: pop only
      step(0, 1, 32'h200, 32'hB5, 32'h5000, 0, 0, 0);  // accepted
      repeat (6) idle(1);

      // 3: youngest match wins
      step(0, 1, 32'h20, 32'h1111, 32'h10, 0, 0, 0);
      step(0, 1, 32'h20, 32'h2222, 32'h14, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h22);
      chk("t3_hit_data", ld_data, 32'h2222);
      step(0, 0, 0, 0, 0, 0, 1, 32'h24);
      repeat (3) idle(1);

      // 4: streaming with memory always ready, pointers wrap
      for (int i = 0; i < 10; i++) step(0, 1, 32'h400 + 4*i, 32'hC000 + i, 32'h6000 + 4*i, 1, 0, 0);
      repeat (2) idle(1);

      // 5: a store in flight is not visible to a same-cycle load
      step(0, 1, 32'h30, 32'h3333, 32'h20, 0, 1, 32'h30);
      step(0, 0, 0, 0, 0, 0, 1, 32'h30);
      repeat (2) idle(1);

      // 6: reset with push and pop pending
      for (int i = 0; i < 3; i++) step(0, 1, 32'h500 + 4*i, 32'hE0 + i, 32'h7000, 0, 0, 0);
      step(1, 1, 32'h600, 32'hFF, 32'h7100, 1, 0, 0);
      idle(0);

      // random traffic with a small address pool so loads hit often
      for (int i = 0; i < 400; i++) begin
         ra = {$urandom_range(0, 3), 18'h0, 10'($urandom_range(0, 5)), 2'($urandom)};
         step(($urandom_range(0, 99) == 0), 1'($urandom), ra, $urandom, $urandom,
              1'($urandom), 1'($urandom),
              {$urandom_range(0, 3), 18'h0, 10'($urandom_range(0, 5)), 2'($urandom)});
      end
      repeat (6) idle(1);
      chk("drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
